// File: rtl/cnn_load_sequencer.sv
// Streams signed weight bytes into feature, bias and fully-connected word buffers,
// writes each word out, then starts the CNN and captures its result.
// Optional feature: define CNN_RUN_ONLY_EN to re-run the CNN on already-loaded weights.
module cnn_load_sequencer #(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_FEATURES = 3,
    parameter int FC_WORDS     = 27
) (
    input  logic                                   clk,
    input  logic                                   rst_seq,
    input  logic                                   start,
`ifdef CNN_RUN_ONLY_EN
    input  logic                                   run_only,
`endif
    input  logic [DATA_WIDTH-1:0]                  s_data,
    input  logic                                   s_valid,
    output logic                                   s_ready,
    output logic [16*DATA_WIDTH-1:0]               feature_weights_output,
    output logic [1:0]                             feature_writeAddr,
    output logic                                   feature_WrEn,
    output logic [(NUM_FEATURES+1)*DATA_WIDTH-1:0] bias_weights_output,
    output logic                                   bias_WrEn,
    output logic [16*DATA_WIDTH-1:0]               fullyconnected_weights_output,
    output logic [4:0]                             fullyconnected_writeAddr,
    output logic                                   fullyconnected_WrEn,
    output logic                                   convolution_enable,
    input  logic                                   cnn_done,
    input  logic [DATA_WIDTH-1:0]                  cnn_output,
    output logic                                   busy,
    output logic                                   done,
    output logic [DATA_WIDTH-1:0]                  result,
    output logic [2:0]                             state_dbg
);
    localparam int WORD_LEN = 16;
    localparam int BIAS_LEN = NUM_FEATURES + 1;
    localparam int MAX_LEN  = (BIAS_LEN > WORD_LEN) ? BIAS_LEN : WORD_LEN;
    localparam int LANE_W   = $clog2(MAX_LEN);

    typedef enum logic [2:0] {
        IDLE, LOAD_FEAT, LOAD_BIAS, LOAD_FC, WRITE, START_CNN, WAIT_CNN, DONE
    } state_t;

    state_t            state, state_next, phase;
    logic [LANE_W-1:0] lane;
    logic              wr_cnt;
    logic              accept;
    logic              last_byte;
    logic              skip_load;

`ifdef CNN_RUN_ONLY_EN
    logic weights_loaded;
    assign skip_load = run_only && weights_loaded;
`else
    assign skip_load = 1'b0;
`endif

    assign state_dbg = state;
    // Handshake: a byte moves on a rising edge where s_valid && s_ready; s_ready is
    // high only in the LOAD_* states, so bytes offered elsewhere are left untouched.
    assign accept    = s_ready && s_valid;
    assign last_byte = (state == LOAD_BIAS) ? (lane == LANE_W'(BIAS_LEN - 1))
                                            : (lane == LANE_W'(WORD_LEN - 1));

    always_ff @(posedge clk) begin
        if (rst_seq) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next          = state;
        s_ready             = 1'b0;
        busy                = (state != IDLE);
        done                = 1'b0;
        convolution_enable  = 1'b1;
        feature_WrEn        = 1'b1;
        bias_WrEn           = 1'b1;
        fullyconnected_WrEn = 1'b1;
        case (state)
            IDLE: begin
                if (start) state_next = skip_load ? START_CNN : LOAD_FEAT;
            end
            LOAD_FEAT, LOAD_BIAS, LOAD_FC: begin
                s_ready = 1'b1;
                if (s_valid && last_byte) state_next = WRITE;
            end
            WRITE: begin
                feature_WrEn        = (phase != LOAD_FEAT);
                bias_WrEn           = (phase != LOAD_BIAS);
                fullyconnected_WrEn = (phase != LOAD_FC);
                // wr_cnt marks the second of the two write-strobe cycles
                if (wr_cnt) begin
                    case (phase)
                        LOAD_FEAT: state_next = (feature_writeAddr == 2'(NUM_FEATURES - 1))
                                                ? LOAD_BIAS : LOAD_FEAT;
                        LOAD_BIAS: state_next = LOAD_FC;
                        default:   state_next = (fullyconnected_writeAddr == 5'(FC_WORDS - 1))
                                                ? START_CNN : LOAD_FC;
                    endcase
                end
            end
            START_CNN: begin
                convolution_enable = 1'b0;
                state_next         = WAIT_CNN;
            end
            WAIT_CNN: begin
                if (cnn_done) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_seq) begin
            feature_weights_output        <= '0;
            bias_weights_output           <= '0;
            fullyconnected_weights_output <= '0;
            feature_writeAddr             <= '0;
            fullyconnected_writeAddr      <= '0;
            lane                          <= '0;
            wr_cnt                        <= 1'b0;
            phase                         <= IDLE;
            result                        <= '0;
`ifdef CNN_RUN_ONLY_EN
            weights_loaded                <= 1'b0;
`endif
        end else begin
            if (state == IDLE && start && !skip_load) begin
                feature_writeAddr        <= '0;
                fullyconnected_writeAddr <= '0;
                lane                     <= '0;
            end
            if (accept) begin
                for (int k = 0; k < WORD_LEN; k++) begin
                    if (state == LOAD_FEAT && lane == LANE_W'(k))
                        feature_weights_output[k*DATA_WIDTH +: DATA_WIDTH] <= s_data;
                    if (state == LOAD_FC && lane == LANE_W'(k))
                        fullyconnected_weights_output[k*DATA_WIDTH +: DATA_WIDTH] <= s_data;
                end
                for (int k = 0; k < BIAS_LEN; k++) begin
                    if (state == LOAD_BIAS && lane == LANE_W'(k))
                        bias_weights_output[k*DATA_WIDTH +: DATA_WIDTH] <= s_data;
                end
                phase <= state;
                if (!last_byte) lane <= lane + LANE_W'(1);
            end
            if (state == WRITE) begin
                wr_cnt <= ~wr_cnt;
                if (wr_cnt) begin
                    lane <= '0;
                    if (phase == LOAD_FEAT) feature_writeAddr <= feature_writeAddr + 2'd1;
                    if (phase == LOAD_FC)
                        fullyconnected_writeAddr <= fullyconnected_writeAddr + 5'd1;
                end
            end
            if (state == WAIT_CNN && cnn_done) result <= cnn_output;
`ifdef CNN_RUN_ONLY_EN
            if (state == WRITE && state_next == START_CNN) weights_loaded <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_cnn_load_sequencer.sv
// Self-checking bench for cnn_load_sequencer: scoreboarded word writes, CNN start
// latency, result capture, mid-load reset and (with CNN_RUN_ONLY_EN) run-only restarts.
module tb_cnn_load_sequencer;
    localparam int DW  = 8;
    localparam int NF  = 3;
    localparam int FCW = 27;
    localparam int W   = 2 + 5 + 16 * DW;

    logic                   clk = 1'b0;
    logic                   rst_seq, start, run_only, s_valid, s_ready, cnn_done;
    logic [DW-1:0]          s_data, cnn_output, result;
    logic [16*DW-1:0]       feature_weights_output, fullyconnected_weights_output;
    logic [(NF+1)*DW-1:0]   bias_weights_output;
    logic [1:0]             feature_writeAddr;
    logic [4:0]             fullyconnected_writeAddr;
    logic                   feature_WrEn, bias_WrEn, fullyconnected_WrEn;
    logic                   convolution_enable, busy, done;
    logic [2:0]             state_dbg;

    logic [W-1:0] exp_q[$];
    int vec_cnt = 0, err_cnt = 0;
    int cyc = 0, last_fc = 0, low_run = 0, conv_low = 0, done_cnt = 0;
    bit run_only_mode = 1'b0;

    cnn_load_sequencer #(.DATA_WIDTH(DW), .NUM_FEATURES(NF), .FC_WORDS(FCW)) dut (
        .clk                           (clk),
        .rst_seq                       (rst_seq),
        .start                         (start),
`ifdef CNN_RUN_ONLY_EN
        .run_only                      (run_only),
`endif
        .s_data                        (s_data),
        .s_valid                       (s_valid),
        .s_ready                       (s_ready),
        .feature_weights_output        (feature_weights_output),
        .feature_writeAddr             (feature_writeAddr),
        .feature_WrEn                  (feature_WrEn),
        .bias_weights_output           (bias_weights_output),
        .bias_WrEn                     (bias_WrEn),
        .fullyconnected_weights_output (fullyconnected_weights_output),
        .fullyconnected_writeAddr      (fullyconnected_writeAddr),
        .fullyconnected_WrEn           (fullyconnected_WrEn),
        .convolution_enable            (convolution_enable),
        .cnn_done                      (cnn_done),
        .cnn_output                    (cnn_output),
        .busy                          (busy),
        .done                          (done),
        .result                        (result),
        .state_dbg                     (state_dbg)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_value(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // monitor: word writes against the scoreboard, strobe widths, CNN start latency
    always @(negedge clk) begin
        int nlow;
        logic [W-1:0] obs;
        nlow = int'(!feature_WrEn) + int'(!bias_WrEn) + int'(!fullyconnected_WrEn);
        if (nlow != 0) begin
            check_value("wren_onehot", W'(nlow), W'(1));
            if (!feature_WrEn)
                obs = {2'd1, 3'b000, feature_writeAddr, feature_weights_output};
            else if (!bias_WrEn)
                obs = {2'd2, 5'd0, {(16-(NF+1))*DW{1'b0}}, bias_weights_output};
            else
                obs = {2'd3, fullyconnected_writeAddr, fullyconnected_weights_output};
            low_run++;
            if (exp_q.size() == 0) begin
                check_value("wr_unexpected", obs, W'(0));
            end else begin
                check_value("wr_word", obs, exp_q[0]);
                if (low_run == 2) void'(exp_q.pop_front());
            end
        end else if (low_run != 0) begin
            check_value("wr_len", W'(low_run), W'(2));
            low_run = 0;
        end
        if (!fullyconnected_WrEn) last_fc = cyc;
        if (!convolution_enable) begin
            conv_low++;
            if (!run_only_mode) check_value("conv_latency", W'(cyc - last_fc), W'(1));
        end
        if (done) done_cnt++;
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int  n;
        logic acc;
        for (int i = 0; i < gap; i++) begin
            s_valid = 1'b0;
            s_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        s_valid = 1'b1;
        s_data  = b;
        n = 0;
        forever begin
            acc = s_ready;
            @(posedge clk); #1;
            if (acc) break;
            n++;
            if (n > 100) begin
                check_value("byte_timeout", W'(1), W'(0));
                break;
            end
        end
        s_valid = 1'b0;
        s_data  = 8'($urandom);
    endtask

    // mode 0: valid always high, 1: valid toggles, 2: random gaps
    task automatic load_weights(input int mode, input int max_bytes, input bit fixed, input bit inject);
        logic [7:0]       w[16];
        logic [16*DW-1:0] pw;
        logic [1:0]       kind;
        logic [4:0]       addr;
        int sent, len, gap;
        sent = 0;
        for (int word = 0; word < NF + 1 + FCW; word++) begin
            if (word < NF) begin
                len = 16; kind = 2'd1; addr = 5'(word);
            end else if (word == NF) begin
                len = NF + 1; kind = 2'd2; addr = 5'd0;
            end else begin
                len = 16; kind = 2'd3; addr = 5'(word - NF - 1);
            end
            for (int k = 0; k < 16; k++) w[k] = 8'($urandom);
            if (fixed && word == 0) begin
                w[0] = 8'(-53); w[1] = 8'd43; w[15] = 8'd26;
            end
            if (fixed && word == NF) begin
                w[0] = 8'd10; w[1] = 8'd0; w[2] = 8'd0; w[3] = 8'(-8);
            end
            pw = '0;
            for (int k = 0; k < len; k++) begin
                if (sent == max_bytes) return;
                gap = (mode == 0) ? 0 : (mode == 1) ? 1 : $urandom_range(0, 2);
                if (inject && kind == 2'd3 && addr == 5'd5 && k == 0) begin
                    cnn_output = 8'd99;
                    cnn_done   = 1'b1;
                end
                send_byte(w[k], gap);
                cnn_done = 1'b0;
                sent++;
                pw[k*DW +: DW] = w[k];
            end
            exp_q.push_back({kind, addr, pw});
        end
    endtask

    task automatic finish_cnn(input logic [7:0] val, input int base_conv, input int base_done);
        int n;
        n = 0;
        while (conv_low == base_conv && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check_value("conv_pulses", W'(conv_low), W'(base_conv + 1));
        check_value("wait_s_ready", W'(s_ready), W'(0));
        check_value("sb_drained", W'(exp_q.size()), W'(0));
        repeat (2) @(posedge clk);
        #1;
        check_value("conv_width", W'(conv_low), W'(base_conv + 1));
        cnn_output = val;
        cnn_done   = 1'b1;
        @(posedge clk); #1;
        cnn_done   = 1'b0;
        check_value("done_pulse", W'(done), W'(1));
        check_value("result_cap", W'(result), W'(val));
        @(posedge clk); #1;
        check_value("done_clear", W'(done), W'(0));
        check_value("idle_busy", W'(busy), W'(0));
        check_value("result_hold", W'(result), W'(val));
        check_value("done_count", W'(done_cnt), W'(base_done + 1));
    endtask

    task automatic full_run(input int mode, input logic [7:0] val, input bit fixed, input bit inject);
        int base_conv, base_done;
        logic [7:0] prev;
        base_conv = conv_low;
        base_done = done_cnt;
        prev      = result;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_value("busy_after_start", W'(busy), W'(1));
        check_value("load_s_ready", W'(s_ready), W'(1));
        load_weights(mode, 484, fixed, inject);
        check_value("result_untouched", W'(result), W'(prev));
        finish_cnn(val, base_conv, base_done);
    endtask

    task automatic check_reset_outputs();
        check_value("rst_s_ready", W'(s_ready), W'(0));
        check_value("rst_busy", W'(busy), W'(0));
        check_value("rst_done", W'(done), W'(0));
        check_value("rst_result", W'(result), W'(0));
        check_value("rst_wren", W'({feature_WrEn, bias_WrEn, fullyconnected_WrEn}), W'(3'b111));
        check_value("rst_conv_en", W'(convolution_enable), W'(1));
        check_value("rst_feat", W'(feature_weights_output), W'(0));
        check_value("rst_bias", W'(bias_weights_output), W'(0));
        check_value("rst_fc", W'(fullyconnected_weights_output), W'(0));
        check_value("rst_addr", W'({feature_writeAddr, fullyconnected_writeAddr}), W'(0));
    endtask

    initial begin
        int base_conv, base_done;
        rst_seq = 1'b1; start = 1'b0; run_only = 1'b0; s_valid = 1'b0; s_data = '0;
        cnn_done = 1'b0; cnn_output = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_seq = 1'b0;
        check_reset_outputs();

        full_run(0, 8'd7, 1'b1, 1'b1);

`ifdef CNN_RUN_ONLY_EN
        run_only_mode = 1'b1;
        run_only      = 1'b1;
        base_conv     = conv_low;
        base_done     = done_cnt;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_value("ro_conv_en", W'(convolution_enable), W'(0));
        check_value("ro_s_ready", W'(s_ready), W'(0));
        finish_cnn(8'd5, base_conv, base_done);
        run_only_mode = 1'b0;
        run_only      = 1'b0;
`endif

        full_run(1, 8'd200, 1'b1, 1'b0);

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        load_weights(0, 200, 1'b0, 1'b0);
        rst_seq = 1'b1;
        @(posedge clk); #1;
        rst_seq = 1'b0;
        check_value("abort_sb_empty", W'(exp_q.size()), W'(0));
        check_reset_outputs();
        base_done = done_cnt;

        run_only = 1'b1;
        full_run(2, 8'(-3), 1'b0, 1'b0);
        run_only = 1'b0;
        check_value("final_done_total", W'(done_cnt), W'(base_done + 1));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/cnn_load_sequencer.md
CNN_LOAD_SEQUENCER -- requirements
Module: cnn_load_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of every weight byte and of the result.
REQ-002 SHALL have parameter NUM_FEATURES, default 3, number of feature maps loaded.
REQ-003 SHALL have parameter FC_WORDS, default 27, number of 16-lane fully-connected words (432/16).
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk, input, 1, rising-edge clock.
REQ-006 SHALL have port rst_seq, input, 1, synchronous active-high reset.
REQ-007 SHALL have port start, input, 1, begin load-and-run; sampled only in IDLE.
REQ-008 SHALL have ports s_data (input, DATA_WIDTH, signed weight byte), s_valid (input, 1) and s_ready (output, 1); a byte transfers when both valid and ready are high on a rising edge.
REQ-009 SHALL have ports feature_weights_output (output, 16 x DATA_WIDTH), feature_writeAddr (output, 2) and feature_WrEn (output, 1, active-low).
REQ-010 SHALL have ports bias_weights_output (output, (NUM_FEATURES+1) x DATA_WIDTH) and bias_WrEn (output, 1, active-low).
REQ-011 SHALL have ports fullyconnected_weights_output (output, 16 x DATA_WIDTH), fullyconnected_writeAddr (output, 5) and fullyconnected_WrEn (output, 1, active-low).
REQ-012 SHALL have port convolution_enable, output, 1, active-low start pulse to the CNN.
REQ-013 SHALL have ports cnn_done (input, 1, one-cycle completion pulse from the CNN) and cnn_output (input, DATA_WIDTH, CNN result).
REQ-014 SHALL have ports busy (output, 1, high outside IDLE), done (output, 1, one-cycle pulse) and result (output, DATA_WIDTH, registered CNN result).

Function
REQ-015 FSM states SHALL be IDLE, LOAD_FEAT, LOAD_BIAS, LOAD_FC, WRITE, START_CNN, WAIT_CNN and DONE.
REQ-016 IDLE->LOAD_FEAT SHALL occur on start=1; start SHALL be ignored in every other state.
REQ-017 s_ready SHALL be 1 only in the LOAD_* states; all other states SHALL hold it at 0.
REQ-018 A lane counter SHALL place the k-th accepted byte of a word into element k of the active output array, starting at element 0.
REQ-019 Word size SHALL be 16 bytes in LOAD_FEAT and LOAD_FC, and NUM_FEATURES+1 bytes in LOAD_BIAS.
REQ-020 On the cycle the last byte of a word is accepted, the FSM SHALL go to WRITE.
REQ-021 WRITE SHALL drive the matching WrEn low for exactly 2 cycles, with data and address stable throughout; then the address SHALL increment and the lane counter SHALL clear.
REQ-022 Phase order SHALL be NUM_FEATURES feature words at addr 0..NUM_FEATURES-1, then 1 bias word, then FC_WORDS FC words at addr 0..FC_WORDS-1.
REQ-023 After the final FC write, the FSM SHALL go to START_CNN.
REQ-024 START_CNN SHALL drive convolution_enable low for exactly 1 cycle, then enter WAIT_CNN.
REQ-025 Latency: if the last FC byte is accepted at edge T, fullyconnected_WrEn SHALL be low in cycles T+1..T+2 and convolution_enable low in cycle T+3.
REQ-026 cnn_done SHALL be honoured only in WAIT_CNN and ignored in every other state.
REQ-027 On cnn_done in WAIT_CNN, result SHALL capture cnn_output and the FSM SHALL go to DONE.
REQ-028 DONE SHALL pulse done=1 for 1 cycle, then return to IDLE; result SHALL hold until the next capture.
REQ-029 s_valid low mid-word SHALL stall the sequencer with no lane advance and no timeout.
REQ-030 Bytes offered while s_ready=0 SHALL be neither consumed nor counted.
REQ-031 Only one WrEn SHALL be low at any time; every WrEn and convolution_enable SHALL idle high.

Reset
REQ-032 rst_seq=1 SHALL, at the next edge and from any state including mid-load or WAIT_CNN, force the FSM to IDLE.
REQ-033 That reset SHALL set s_ready=0, busy=0, done=0 and result=0.
REQ-034 That reset SHALL drive all WrEn and convolution_enable high.
REQ-035 That reset SHALL zero all weight output arrays, addresses and lane counters.
REQ-036 That reset SHALL clear the weights_loaded flag; a partially written word SHALL be abandoned.

Configuration
REQ-037 Macro CNN_RUN_ONLY_EN SHALL, when defined, add input port run_only (1 bit) and an internal weights_loaded flag, set on entering START_CNN from the load path.
REQ-038 With CNN_RUN_ONLY_EN defined, start=1 with run_only=1 and weights_loaded=1 SHALL go IDLE->START_CNN with no bytes consumed; run_only=1 with weights_loaded=0 SHALL perform a full load.
REQ-039 Without CNN_RUN_ONLY_EN, the run_only port and flag SHALL be absent and every start SHALL perform a full 484-byte load.

Verification
REQ-040 Full load of 484 bytes with s_valid always high -> 3 feature writes, 1 bias write {10,0,0,-8}, 27 FC writes at addr 0..26, then one convolution_enable low cycle at T+3.
REQ-041 Feature word -53,43,...,26 at addr 0 -> feature_weights_output matches in lane order while feature_WrEn=0 for exactly 2 cycles.
REQ-042 s_valid toggled 1/0 every cycle -> same write sequence and data as REQ-040; no byte dropped or duplicated.
REQ-043 cnn_done pulse with cnn_output=7 in WAIT_CNN -> result=7 and done=1 for one cycle next; a cnn_done pulse during LOAD_FC has no effect.
REQ-044 rst_seq=1 after the 200th byte -> IDLE, all outputs at reset values; a subsequent start reloads from feature addr 0.
REQ-045 With CNN_RUN_ONLY_EN defined, a second start with run_only=1 -> convolution_enable pulses 1 cycle after start, s_ready stays 0.
